// File: rtl/rcvr_ctlr_if.sv
// rcvr_ctlr_if: bundles the serial-receiver handshake, the two-consumer grant bus and the
// FIFO status flags of rcvr_ctlr.
//   rx_ready/rx_overrun/rx_data : receiver -> controller
//   rx_reading                  : controller -> receiver acknowledge
//   req                         : consumer requests, bit i = consumer i
//   gnt/dout                    : one-hot grant pulse with the delivered byte
//   empty/full/lost             : registered FIFO status and sticky overrun flag
//   lost_cnt                    : saturating overrun count (only with RCVR_CTLR_STATS_EN)
// Modport slave is the controller side; modport master is the environment side.
interface rcvr_ctlr_if;
  logic       rx_ready;
  logic       rx_overrun;
  logic [7:0] rx_data;
  logic       rx_reading;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       lost;
`ifdef RCVR_CTLR_STATS_EN
  logic [7:0] lost_cnt;

  modport slave (
    input  rx_ready, rx_overrun, rx_data, req,
    output rx_reading, gnt, dout, empty, full, lost, lost_cnt
  );

  modport master (
    output rx_ready, rx_overrun, rx_data, req,
    input  rx_reading, gnt, dout, empty, full, lost, lost_cnt
  );
`else
  modport slave (
    input  rx_ready, rx_overrun, rx_data, req,
    output rx_reading, gnt, dout, empty, full, lost
  );

  modport master (
    output rx_ready, rx_overrun, rx_data, req,
    input  rx_reading, gnt, dout, empty, full, lost
  );
`endif
endinterface

// File: rtl/rcvr_ctlr.sv
// rcvr_ctlr: captures bytes from a serial receiver into a DEPTH-entry FIFO and delivers them
// to two consumers through a round-robin arbiter.
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : rcvr_ctlr_if.slave (receiver handshake, consumer requests/grants, status)
// Optional feature: define RCVR_CTLR_STATS_EN to add the saturating overrun counter
// bus.lost_cnt.
module rcvr_ctlr #(
  parameter int unsigned DEPTH = 4  // power of two, 2..16
) (
  input  logic         clock,
  input  logic         reset,
  rcvr_ctlr_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRead, StSettle} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;
  logic            empty_q, full_q, lost_q;
  logic [1:0]      gnt_q;
  logic [7:0]      dout_q;
  logic            prefer_q;  // consumer that wins a tie
  logic            push, pop, rx_reading;
  logic [1:0]      win;

  // Receiver-side FSM: capture in IDLE, acknowledge in READ, ignore rx_ready in SETTLE.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    rx_reading = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Uses pre-edge full: a pop on the same edge does not open a slot for this push.
        if (bus.rx_ready && !full_q) begin
          push    = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        rx_reading = 1'b1;
        state_d    = StSettle;
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Consumer-side arbitration: a lone requester wins; on a tie the preferred one wins.
  always_comb begin
    pop = !empty_q && (bus.req != 2'b00);
    win = bus.req;
    if (bus.req == 2'b11) begin
      win = prefer_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      lost_q   <= 1'b0;
      gnt_q    <= 2'b00;
      dout_q   <= 8'h00;
      prefer_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FullCnt);
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        if (bus.rx_overrun) begin
          lost_q <= 1'b1;
        end
      end
      if (pop) begin
        rptr_q   <= rptr_q + 1'b1;
        gnt_q    <= win;
        dout_q   <= mem_q[rptr_q];
        prefer_q <= ~win[1];  // the consumer not just granted is preferred next
      end else begin
        gnt_q <= 2'b00;
      end
    end
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wptr_q] <= bus.rx_data;
    end
  end

`ifdef RCVR_CTLR_STATS_EN
  logic [7:0] lost_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      lost_cnt_q <= 8'h00;
    end else if (push && bus.rx_overrun && (lost_cnt_q != 8'hFF)) begin
      lost_cnt_q <= lost_cnt_q + 8'h01;
    end
  end

  assign bus.lost_cnt = lost_cnt_q;
`endif

  assign bus.rx_reading = rx_reading;
  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.lost       = lost_q;

endmodule

// File: tb/tb_rcvr_ctlr.sv
// tb_rcvr_ctlr: table-driven check of rcvr_ctlr (DEPTH=4) plus hand-written sequences for
// back-to-back capture latency and overrun counter saturation.
module tb_rcvr_ctlr;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rcvr_ctlr_if bus ();

  rcvr_ctlr #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       ovr;
    logic [7:0] data;
    logic [1:0] req;
    logic       rdg;
    logic [1:0] gnt;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       lost;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic rst, logic rdy, logic ovr, logic [7:0] data, logic [1:0] req,
                              logic rdg, logic [1:0] gnt, logic [7:0] dout, logic empty,
                              logic full, logic lost);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.ovr = ovr; v.data = data; v.req = req;
    v.rdg = rdg; v.gnt = gnt; v.dout = dout; v.empty = empty; v.full = full; v.lost = lost;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic ovr, input logic [7:0] data,
                       input logic [1:0] req);
    reset          = rst;
    bus.rx_ready   = rdy;
    bus.rx_overrun = ovr;
    bus.rx_data    = data;
    bus.req        = req;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int t1, t2, pulses;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);

    //   rst rdy ovr data   req    rdg gnt    dout   emp ful lost
    // Single capture, ack timing, ignored rx_ready in READ/SETTLE, ordered delivery.
    add(1, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 1, 0, 0);  // 0
    add(0, 1, 0, 8'h3C, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 1 capture
    vecs[1].rdg = 1'b1;
    add(0, 1, 1, 8'hAA, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 2 READ, no capture
    add(0, 1, 0, 8'hAA, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 3 SETTLE
    add(0, 1, 0, 8'hAA, 2'b00,  1, 2'b00, 8'h00, 0, 0, 0);  // 4 capture
    add(0, 0, 0, 8'h00, 2'b01,  0, 2'b01, 8'h3C, 0, 0, 0);  // 5 pop
    add(0, 0, 0, 8'h00, 2'b01,  0, 2'b01, 8'hAA, 1, 0, 0);  // 6 pop
    add(0, 0, 0, 8'h00, 2'b01,  0, 2'b00, 8'hAA, 1, 0, 0);  // 7 empty: dout holds
    // Round-robin with both consumers requesting.
    add(1, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 1, 0, 0);  // 8
    add(0, 1, 0, 8'h11, 2'b00,  1, 2'b00, 8'h00, 0, 0, 0);  // 9
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 10
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 11
    add(0, 1, 0, 8'h22, 2'b00,  1, 2'b00, 8'h00, 0, 0, 0);  // 12
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 13
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 14
    add(0, 1, 0, 8'h33, 2'b00,  1, 2'b00, 8'h00, 0, 0, 0);  // 15
    add(0, 0, 0, 8'h00, 2'b11,  0, 2'b01, 8'h11, 0, 0, 0);  // 16
    add(0, 0, 0, 8'h00, 2'b11,  0, 2'b10, 8'h22, 0, 0, 0);  // 17
    add(0, 0, 0, 8'h00, 2'b11,  0, 2'b01, 8'h33, 1, 0, 0);  // 18
    add(0, 0, 0, 8'h00, 2'b11,  0, 2'b00, 8'h33, 1, 0, 0);  // 19
    // Fill to full, no capture while full, pop frees a slot, push+pop, pointer wrap.
    add(1, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 1, 0, 0);  // 20
    add(0, 1, 0, 8'h01, 2'b00,  1, 2'b00, 8'h00, 0, 0, 0);  // 21
    add(0, 1, 0, 8'h02, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 22
    add(0, 1, 0, 8'h02, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 23
    add(0, 1, 0, 8'h02, 2'b00,  1, 2'b00, 8'h00, 0, 0, 0);  // 24
    add(0, 1, 0, 8'h03, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 25
    add(0, 1, 0, 8'h03, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 26
    add(0, 1, 0, 8'h03, 2'b00,  1, 2'b00, 8'h00, 0, 0, 0);  // 27
    add(0, 1, 0, 8'h04, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 28
    add(0, 1, 0, 8'h04, 2'b00,  0, 2'b00, 8'h00, 0, 0, 0);  // 29
    add(0, 1, 0, 8'h04, 2'b00,  1, 2'b00, 8'h00, 0, 1, 0);  // 30 full
    add(0, 1, 0, 8'h05, 2'b00,  0, 2'b00, 8'h00, 0, 1, 0);  // 31
    add(0, 1, 0, 8'h05, 2'b00,  0, 2'b00, 8'h00, 0, 1, 0);  // 32
    add(0, 1, 0, 8'h05, 2'b00,  0, 2'b00, 8'h00, 0, 1, 0);  // 33 IDLE, full: no ack
    add(0, 1, 0, 8'h05, 2'b00,  0, 2'b00, 8'h00, 0, 1, 0);  // 34
    add(0, 1, 0, 8'h05, 2'b01,  0, 2'b01, 8'h01, 0, 0, 0);  // 35 pop only
    add(0, 1, 0, 8'h05, 2'b00,  1, 2'b00, 8'h01, 0, 1, 0);  // 36 capture
    add(0, 1, 0, 8'h06, 2'b01,  0, 2'b01, 8'h02, 0, 0, 0);  // 37
    add(0, 1, 0, 8'h06, 2'b00,  0, 2'b00, 8'h02, 0, 0, 0);  // 38
    add(0, 1, 0, 8'h06, 2'b01,  1, 2'b01, 8'h03, 0, 0, 0);  // 39 push+pop
    add(0, 0, 0, 8'h00, 2'b01,  0, 2'b01, 8'h04, 0, 0, 0);  // 40
    add(0, 0, 0, 8'h00, 2'b01,  0, 2'b01, 8'h05, 0, 0, 0);  // 41
    add(0, 0, 0, 8'h00, 2'b01,  0, 2'b01, 8'h06, 1, 0, 0);  // 42
    // Sticky lost, then reset while in READ with two bytes buffered.
    add(1, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 1, 0, 0);  // 43
    add(0, 1, 1, 8'h77, 2'b00,  1, 2'b00, 8'h00, 0, 0, 1);  // 44
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 0, 0, 1);  // 45
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h00, 0, 0, 1);  // 46
    add(0, 0, 0, 8'h00, 2'b01,  0, 2'b01, 8'h77, 1, 0, 1);  // 47
    add(0, 1, 0, 8'hA1, 2'b00,  1, 2'b00, 8'h77, 0, 0, 1);  // 48
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h77, 0, 0, 1);  // 49
    add(0, 0, 0, 8'h00, 2'b00,  0, 2'b00, 8'h77, 0, 0, 1);  // 50
    add(0, 1, 0, 8'hA2, 2'b00,  1, 2'b00, 8'h77, 0, 0, 1);  // 51 READ, 2 buffered
    add(1, 1, 1, 8'hFF, 2'b11,  0, 2'b00, 8'h00, 1, 0, 0);  // 52 reset dominates
    add(0, 0, 0, 8'h00, 2'b11,  0, 2'b00, 8'h00, 1, 0, 0);  // 53 contents gone

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].ovr, vecs[i].data, vecs[i].req);
      step();
      chk("rx_reading", i, 32'(bus.rx_reading), 32'(vecs[i].rdg));
      chk("gnt",        i, 32'(bus.gnt),        32'(vecs[i].gnt));
      chk("dout",       i, 32'(bus.dout),       32'(vecs[i].dout));
      chk("empty",      i, 32'(bus.empty),      32'(vecs[i].empty));
      chk("full",       i, 32'(bus.full),       32'(vecs[i].full));
      chk("lost",       i, 32'(bus.lost),       32'(vecs[i].lost));
    end

    // Back-to-back latency with rx_ready held: ack pulses three cycles apart.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    step();
    drive(1'b0, 1'b1, 1'b0, 8'h5A, 2'b01);
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 20 && t2 < 0; c++) begin
      step();
      if (bus.rx_reading) begin
        if (t1 < 0) t1 = c;
        else        t2 = c;
      end
    end
    if (t2 < 0) begin
      checks++;
      errors++;
      $display("FAIL b2b_latency: second ack not seen within 20 cycles (got none, need one)");
    end else begin
      chk("b2b_latency", 0, 32'(t2 - t1), 32'd3);
    end

    // 300 overrun captures, drained by consumer 0; counter saturates.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    step();
    drive(1'b0, 1'b1, 1'b1, 8'hE7, 2'b01);
    step();
    chk("lost_first", 0, 32'(bus.lost), 32'd1);
`ifdef RCVR_CTLR_STATS_EN
    chk("lost_cnt_first", 0, 32'(bus.lost_cnt), 32'd1);
`endif
    pulses = bus.rx_reading ? 1 : 0;
    for (int c = 1; c < 900; c++) begin
      step();
      if (bus.rx_reading) pulses++;
    end
    chk("capture_count", 0, 32'(pulses), 32'd300);
    chk("lost_sticky", 0, 32'(bus.lost), 32'd1);
`ifdef RCVR_CTLR_STATS_EN
    chk("lost_cnt_sat", 0, 32'(bus.lost_cnt), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
